// File: rtl/except_detect_mem_pipe_if.sv
// MEM-stage exception detector bundle.
// Upstream request, downstream result and status signals.
interface except_detect_mem_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int EXC_W  = 32,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [EXC_W-1:0]  excepttype_i;
    logic [ADDR_W-1:0] access_addr_i;
    logic              load_en_i;
    logic              store_en_i;
    logic [1:0]        size_i;
    logic              unalign_ok_i;
    logic              branch_state_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic [ADDR_W-1:0] pc_i;
    logic              out_valid;
    logic              out_ready;
    logic [EXC_W-1:0]  excepttype_o;
    logic [ADDR_W-1:0] badvaddr_o;
    logic [4:0]        exc_code_o;
    logic [ADDR_W-1:0] epc_o;
    logic              exc_taken_o;
    logic [CNT_W-1:0]  exc_count_o;

    modport master (
        output in_valid, excepttype_i, access_addr_i, load_en_i,
        output store_en_i, size_i, unalign_ok_i, branch_state_i,
        output branch_target_i, pc_i, out_ready,
        input  in_ready, out_valid, excepttype_o, badvaddr_o,
        input  exc_code_o, epc_o, exc_taken_o, exc_count_o
    );

    modport slave (
        input  in_valid, excepttype_i, access_addr_i, load_en_i,
        input  store_en_i, size_i, unalign_ok_i, branch_state_i,
        input  branch_target_i, pc_i, out_ready,
        output in_ready, out_valid, excepttype_o, badvaddr_o,
        output exc_code_o, epc_o, exc_taken_o, exc_count_o
    );
endinterface

// File: rtl/except_detect_mem_pipe.sv
// MEM-stage address-exception detector with registered output.
// Locks after handing off an exception until the pipeline flush.
module except_detect_mem_pipe #(
    parameter int ADDR_W      = 32,
    parameter int EXC_W       = 32,
    parameter int BIT_ADEL_IF = 4,
    parameter int BIT_ADEL_LD = 5,
    parameter int BIT_ADES    = 6,
    parameter bit DW_EN       = 1'b0,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    except_detect_mem_pipe_if.slave bus
);
    typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_valid;
    logic [EXC_W-1:0]  r_exc;
    logic [ADDR_W-1:0] r_badv;
    logic [4:0]        r_code;
    logic [ADDR_W-1:0] r_epc;
    logic              r_taken;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_mask;
    logic              w_mis;
    logic              w_ld;
    logic              w_st;
    logic              w_ifm;
    logic [EXC_W-1:0]  w_exc;
    logic [ADDR_W-1:0] w_badv;
    logic [4:0]        w_code;
    logic              w_in_ready;
    logic              w_handoff;
    logic              w_load;

    // Alignment mask from access size; size 3 is dword only when enabled
    always_comb begin
        w_mask = 3'b000;
        unique case (bus.size_i)
            2'd0: w_mask = 3'b000;
            2'd1: w_mask = 3'b001;
            2'd2: w_mask = 3'b011;
            2'd3: w_mask = DW_EN ? 3'b111 : 3'b011;
        endcase
    end

    assign w_mis = (|(bus.access_addr_i[2:0] & w_mask)) & ~bus.unalign_ok_i;
    assign w_ld  = bus.load_en_i & w_mis;
    assign w_st  = bus.store_en_i & ~bus.load_en_i & w_mis;
    assign w_ifm = bus.branch_state_i & (|bus.branch_target_i[1:0]);

    // Overwrite the three address-error bits, pass all others through
    always_comb begin
        w_exc              = bus.excepttype_i;
        w_exc[BIT_ADEL_IF] = w_ifm;
        w_exc[BIT_ADEL_LD] = w_ld;
        w_exc[BIT_ADES]    = w_st;
    end

    // Faulting address and ExcCode: fetch target beats load beats store
    always_comb begin
        w_badv = '0;
        w_code = 5'd0;
        priority case (1'b1)
            w_ifm: begin
                w_badv = bus.branch_target_i;
                w_code = 5'd4;
            end
            w_ld: begin
                w_badv = bus.access_addr_i;
                w_code = 5'd4;
            end
            w_st: begin
                w_badv = bus.access_addr_i;
                w_code = 5'd5;
            end
            default: begin
                w_badv = '0;
                w_code = 5'd0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    // Next state: lock on exception hand-off, only flush unlocks
    always_comb begin
        w_state_nxt = r_state;
        if (flush)          w_state_nxt = RUN;
        else if (w_handoff) w_state_nxt = LOCK;
    end

    // Handshake outputs; inputs arriving with a hand-off or flush are dropped
    always_comb begin
        w_in_ready = (r_state == LOCK) | ~r_valid | bus.out_ready;
        w_handoff  = r_valid & bus.out_ready & (|r_exc);
        w_load     = bus.in_valid & w_in_ready & (r_state == RUN)
                   & ~flush & ~w_handoff;
    end

    // Output register, valid flag, hand-off pulse and saturating counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_exc   <= '0;
            r_badv  <= '0;
            r_code  <= 5'd0;
            r_epc   <= '0;
            r_taken <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_taken <= w_handoff;
            if (w_handoff && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_load) begin
                r_exc  <= w_exc;
                r_badv <= w_badv;
                r_code <= w_code;
                r_epc  <= bus.pc_i;
            end
            if (flush)               r_valid <= 1'b0;
            else if (w_load)         r_valid <= 1'b1;
            else if (bus.out_ready)  r_valid <= 1'b0;
            else if (r_state == LOCK) r_valid <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.excepttype_o = r_exc;
    assign bus.badvaddr_o   = r_badv;
    assign bus.exc_code_o   = r_code;
    assign bus.epc_o        = r_epc;
    assign bus.exc_taken_o  = r_taken;
    assign bus.exc_count_o  = r_cnt;
endmodule

// File: tb/tb_except_detect_mem_pipe.sv
// Directed bench for the MEM-stage exception detector.
// Instance a uses DW_EN=0, instance b uses DW_EN=1.
module tb_except_detect_mem_pipe;
    logic clk;
    logic resetn;
    logic flush_a;
    logic flush_b;
    int   checks;
    int   fails;

    except_detect_mem_pipe_if #(.ADDR_W(32), .EXC_W(32), .CNT_W(8)) ia ();
    except_detect_mem_pipe_if #(.ADDR_W(32), .EXC_W(32), .CNT_W(8)) ib ();

    except_detect_mem_pipe #(.DW_EN(1'b0)) u_a (
        .clk(clk), .resetn(resetn), .flush(flush_a), .bus(ia.slave)
    );
    except_detect_mem_pipe #(.DW_EN(1'b1)) u_b (
        .clk(clk), .resetn(resetn), .flush(flush_b), .bus(ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic [31:0] exc,
                         input logic [31:0] addr, input logic ld,
                         input logic st, input logic [1:0] sz,
                         input logic uok, input logic br,
                         input logic [31:0] tgt, input logic [31:0] pc);
        ia.in_valid = v; ia.excepttype_i = exc; ia.access_addr_i = addr;
        ia.load_en_i = ld; ia.store_en_i = st; ia.size_i = sz;
        ia.unalign_ok_i = uok; ia.branch_state_i = br;
        ia.branch_target_i = tgt; ia.pc_i = pc;
    endtask

    task automatic drv_b(input logic v, input logic [31:0] addr,
                         input logic ld, input logic [1:0] sz,
                         input logic uok, input logic [31:0] pc);
        ib.in_valid = v; ib.excepttype_i = '0; ib.access_addr_i = addr;
        ib.load_en_i = ld; ib.store_en_i = 1'b0; ib.size_i = sz;
        ib.unalign_ok_i = uok; ib.branch_state_i = 1'b0;
        ib.branch_target_i = '0; ib.pc_i = pc;
    endtask

    task automatic idle_a();
        drv_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic flush_cycle_a();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
        idle_a(); drv_b(0, 0, 0, 0, 0, 0);
        ia.out_ready = 1'b1; ib.out_ready = 1'b1;
        #12;
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL rst_valid: got %0h want 0", ia.out_valid); end
        checks++; if (ia.excepttype_o !== 32'h0) begin fails++;
            $display("FAIL rst_exc: got %0h want 0", ia.excepttype_o); end
        checks++; if (ia.badvaddr_o !== 32'h0) begin fails++;
            $display("FAIL rst_badv: got %0h want 0", ia.badvaddr_o); end
        checks++; if (ia.exc_code_o !== 5'd0) begin fails++;
            $display("FAIL rst_code: got %0h want 0", ia.exc_code_o); end
        checks++; if (ia.epc_o !== 32'h0) begin fails++;
            $display("FAIL rst_epc: got %0h want 0", ia.epc_o); end
        checks++; if (ia.exc_taken_o !== 1'b0) begin fails++;
            $display("FAIL rst_taken: got %0h want 0", ia.exc_taken_o); end
        checks++; if (ia.exc_count_o !== 8'd0) begin fails++;
            $display("FAIL rst_cnt: got %0h want 0", ia.exc_count_o); end
        checks++; if (ia.in_ready !== 1'b1) begin fails++;
            $display("FAIL rst_rdy: got %0h want 1", ia.in_ready); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_load_misalign();
        drv_a(1, 0, 32'h1000_0002, 1, 0, 2, 0, 0, 0, 32'h400);
        tick();
        checks++; if (ia.out_valid !== 1'b1) begin fails++;
            $display("FAIL ld_valid: got %0h want 1", ia.out_valid); end
        checks++; if (ia.excepttype_o !== 32'h20) begin fails++;
            $display("FAIL ld_exc: got %0h want 20", ia.excepttype_o); end
        checks++; if (ia.exc_code_o !== 5'd4) begin fails++;
            $display("FAIL ld_code: got %0h want 4", ia.exc_code_o); end
        checks++; if (ia.badvaddr_o !== 32'h1000_0002) begin fails++;
            $display("FAIL ld_badv: got %0h want 10000002", ia.badvaddr_o); end
        checks++; if (ia.epc_o !== 32'h400) begin fails++;
            $display("FAIL ld_epc: got %0h want 400", ia.epc_o); end
        drv_a(1, 0, 32'h2000, 1, 0, 2, 0, 0, 0, 32'h404);
        tick();
        checks++; if (ia.exc_taken_o !== 1'b1) begin fails++;
            $display("FAIL ld_taken: got %0h want 1", ia.exc_taken_o); end
        checks++; if (ia.exc_count_o !== 8'd1) begin fails++;
            $display("FAIL ld_cnt: got %0h want 1", ia.exc_count_o); end
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL ld_young0: got %0h want 0", ia.out_valid); end
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL ld_lock_valid: got %0h want 0", ia.out_valid); end
        checks++; if (ia.exc_taken_o !== 1'b0) begin fails++;
            $display("FAIL ld_pulse: got %0h want 0", ia.exc_taken_o); end
        checks++; if (ia.in_ready !== 1'b1) begin fails++;
            $display("FAIL ld_lock_rdy: got %0h want 1", ia.in_ready); end
        idle_a();
        flush_cycle_a();
    endtask

    task automatic test_branch_priority();
        drv_a(1, 0, 32'h0000_0003, 0, 1, 1, 0, 1, 32'h8000_0006, 32'h600);
        tick();
        checks++; if (ia.excepttype_o !== 32'h50) begin fails++;
            $display("FAIL br_exc: got %0h want 50", ia.excepttype_o); end
        checks++; if (ia.exc_code_o !== 5'd4) begin fails++;
            $display("FAIL br_code: got %0h want 4", ia.exc_code_o); end
        checks++; if (ia.badvaddr_o !== 32'h8000_0006) begin fails++;
            $display("FAIL br_badv: got %0h want 80000006", ia.badvaddr_o); end
        idle_a();
        tick();
        checks++; if (ia.exc_count_o !== 8'd2) begin fails++;
            $display("FAIL br_cnt: got %0h want 2", ia.exc_count_o); end
    endtask

    task automatic test_flush_lock();
        flush_a = 1'b1;
        drv_a(1, 0, 32'h3, 1, 0, 2, 0, 0, 0, 32'h700);
        tick();
        flush_a = 1'b0;
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL fl_drop: got %0h want 0", ia.out_valid); end
        drv_a(1, 0, 32'h8, 1, 0, 2, 0, 0, 0, 32'h500);
        tick();
        checks++; if (ia.out_valid !== 1'b1) begin fails++;
            $display("FAIL fl_run_valid: got %0h want 1", ia.out_valid); end
        checks++; if (ia.epc_o !== 32'h500) begin fails++;
            $display("FAIL fl_run_epc: got %0h want 500", ia.epc_o); end
        checks++; if (ia.excepttype_o !== 32'h0) begin fails++;
            $display("FAIL fl_run_exc: got %0h want 0", ia.excepttype_o); end
        checks++; if (ia.exc_count_o !== 8'd2) begin fails++;
            $display("FAIL fl_cnt_kept: got %0h want 2", ia.exc_count_o); end
        idle_a();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic        sts   [3];
        logic [1:0]  szs   [3];
        addrs = '{32'h0, 32'h1, 32'h4};
        sts   = '{1'b0, 1'b1, 1'b1};
        szs   = '{2'd2, 2'd0, 2'd2};
        for (int i = 0; i < 3; i++) begin
            drv_a(1, 0, addrs[i], ~sts[i], sts[i], szs[i], 0, 0, 0,
                  32'h100 + 32'(4 * i));
            tick();
            checks++; if (ia.out_valid !== 1'b1) begin fails++;
                $display("FAIL b2b_valid%0d: got %0h want 1", i, ia.out_valid); end
            checks++; if (ia.excepttype_o !== 32'h0 || ia.exc_code_o !== 5'd0)
                begin fails++;
                $display("FAIL b2b_exc%0d: got %0h/%0h want 0/0", i,
                         ia.excepttype_o, ia.exc_code_o); end
            checks++; if (ia.epc_o !== 32'h100 + 32'(4 * i)) begin fails++;
                $display("FAIL b2b_epc%0d: got %0h want %0h", i, ia.epc_o,
                         32'h100 + 32'(4 * i)); end
        end
        idle_a();
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL b2b_drain: got %0h want 0", ia.out_valid); end
    endtask

    task automatic test_stall();
        ia.out_ready = 1'b0;
        drv_a(1, 0, 32'h2, 0, 1, 2, 0, 0, 0, 32'h200);
        tick();
        checks++; if (ia.exc_code_o !== 5'd5 || ia.excepttype_o !== 32'h40)
            begin fails++;
            $display("FAIL st_code: got %0h/%0h want 5/40", ia.exc_code_o,
                     ia.excepttype_o); end
        drv_a(1, 0, 32'h11, 1, 0, 2, 0, 0, 0, 32'h204);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ia.out_valid !== 1'b1 || ia.badvaddr_o !== 32'h2 ||
                          ia.epc_o !== 32'h200) begin fails++;
                $display("FAIL st_hold%0d: got %0h/%0h/%0h want 1/2/200", i,
                         ia.out_valid, ia.badvaddr_o, ia.epc_o); end
            checks++; if (ia.in_ready !== 1'b0 || ia.exc_taken_o !== 1'b0)
                begin fails++;
                $display("FAIL st_rdy%0d: got %0h/%0h want 0/0", i,
                         ia.in_ready, ia.exc_taken_o); end
        end
        idle_a();
        ia.out_ready = 1'b1;
        tick();
        checks++; if (ia.exc_taken_o !== 1'b1 || ia.exc_count_o !== 8'd3)
            begin fails++;
            $display("FAIL st_rel: got %0h/%0h want 1/3", ia.exc_taken_o,
                     ia.exc_count_o); end
        tick();
        checks++; if (ia.exc_taken_o !== 1'b0 || ia.exc_count_o !== 8'd3)
            begin fails++;
            $display("FAIL st_once: got %0h/%0h want 0/3", ia.exc_taken_o,
                     ia.exc_count_o); end
        flush_cycle_a();
    endtask

    task automatic test_passthrough();
        drv_a(1, 32'h21, 32'h10, 1, 0, 2, 0, 0, 0, 32'h800);
        tick();
        checks++; if (ia.excepttype_o !== 32'h01) begin fails++;
            $display("FAIL pt_exc: got %0h want 1", ia.excepttype_o); end
        checks++; if (ia.exc_code_o !== 5'd0 || ia.badvaddr_o !== 32'h0)
            begin fails++;
            $display("FAIL pt_code: got %0h/%0h want 0/0", ia.exc_code_o,
                     ia.badvaddr_o); end
        idle_a();
        tick();
        checks++; if (ia.exc_taken_o !== 1'b1 || ia.exc_count_o !== 8'd4)
            begin fails++;
            $display("FAIL pt_lock: got %0h/%0h want 1/4", ia.exc_taken_o,
                     ia.exc_count_o); end
        drv_a(1, 0, 32'h20, 1, 0, 2, 0, 0, 0, 32'h804);
        tick();
        checks++; if (ia.out_valid !== 1'b0) begin fails++;
            $display("FAIL pt_locked: got %0h want 0", ia.out_valid); end
        idle_a();
        flush_cycle_a();
    endtask

    task automatic test_unalign();
        drv_a(1, 0, 32'h3, 1, 0, 2, 1, 0, 0, 32'h900);
        tick();
        checks++; if (ia.out_valid !== 1'b1 || ia.excepttype_o !== 32'h0)
            begin fails++;
            $display("FAIL ua_ok: got %0h/%0h want 1/0", ia.out_valid,
                     ia.excepttype_o); end
        drv_a(1, 0, 32'h4, 1, 0, 3, 0, 0, 0, 32'h904);
        tick();
        checks++; if (ia.excepttype_o !== 32'h0) begin fails++;
            $display("FAIL ua_sz3w: got %0h want 0", ia.excepttype_o); end
        drv_a(1, 0, 32'h1, 1, 1, 1, 0, 0, 0, 32'h908);
        tick();
        checks++; if (ia.excepttype_o !== 32'h20 || ia.exc_code_o !== 5'd4 ||
                      ia.badvaddr_o !== 32'h1) begin fails++;
            $display("FAIL ua_ldst: got %0h/%0h/%0h want 20/4/1",
                     ia.excepttype_o, ia.exc_code_o, ia.badvaddr_o); end
        idle_a();
        tick();
        flush_cycle_a();
    endtask

    task automatic test_dword_sat();
        drv_b(1, 32'h4, 1, 3, 0, 32'hA00);
        tick();
        checks++; if (ib.excepttype_o !== 32'h20 || ib.exc_code_o !== 5'd4 ||
                      ib.badvaddr_o !== 32'h4) begin fails++;
            $display("FAIL dw_adel: got %0h/%0h/%0h want 20/4/4",
                     ib.excepttype_o, ib.exc_code_o, ib.badvaddr_o); end
        drv_b(0, 0, 0, 0, 0, 0);
        tick();
        flush_b = 1'b1; tick(); flush_b = 1'b0;
        drv_b(1, 32'h4, 1, 3, 1, 32'hA04);
        tick();
        checks++; if (ib.out_valid !== 1'b1 || ib.excepttype_o !== 32'h0)
            begin fails++;
            $display("FAIL dw_uok: got %0h/%0h want 1/0", ib.out_valid,
                     ib.excepttype_o); end
        drv_b(0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 260; i++) begin
            drv_b(1, 32'h2, 1, 2, 0, 32'hB00);
            tick();
            drv_b(0, 0, 0, 0, 0, 0);
            tick();
            flush_b = 1'b1; tick(); flush_b = 1'b0;
            if (i == 252) begin
                checks++; if (ib.exc_count_o !== 8'd254) begin fails++;
                    $display("FAIL sat_pre: got %0d want 254", ib.exc_count_o);
                end
            end
        end
        checks++; if (ib.exc_count_o !== 8'd255) begin fails++;
            $display("FAIL sat_cnt: got %0d want 255", ib.exc_count_o); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_load_misalign();
        test_branch_priority();
        test_flush_lock();
        test_back_to_back();
        test_stall();
        test_passthrough();
        test_unalign();
        test_dword_sat();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
